// File: rtl/stream_demux_pkg.sv
// Shared types and elaboration helpers for the stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // True when the implemented port count fits the selection field.
    function automatic bit num_out_ok(input int num_out, input int sel_width);
        return (num_out >= 1) && (num_out <= (1 << sel_width));
    endfunction

endpackage

// File: rtl/stream_pipe_reg.sv
// Single-entry valid/ready register; refill and drain may happen in the same cycle.
module stream_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         full,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         full_q;
    logic [W-1:0] data_q;

    assign in_ready = !full_q || out_ready;
    assign full     = full_q;
    assign out_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (load && in_ready) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_ready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT stream demux with per-packet destination lock and drop counter.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 2,
    parameter int NUM_OUT   = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    input  logic [SEL_WIDTH-1:0] s_sel,
    input  logic                 s_last,
    output logic [NUM_OUT-1:0]   m_valid,
    input  logic [NUM_OUT-1:0]   m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_last,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam int NSEL = 1 << SEL_WIDTH;
    localparam int PW   = WIDTH + 1 + SEL_WIDTH;

    if (!num_out_ok(NUM_OUT, SEL_WIDTH)) begin : g_bad_num_out
        $error("stream_demux: NUM_OUT must be in 1..2**SEL_WIDTH");
    end

    state_t                 state;
    logic [SEL_WIDTH-1:0]   lock_sel;
    logic [SEL_WIDTH-1:0]   dest;
    logic [SEL_WIDTH-1:0]   dest_q;
    logic [NSEL-1:0]        ready_ext;
    logic [PW-1:0]          reg_out;
    logic                   full_q;
    logic                   accept;
    logic                   dest_ok;
    logic [CNT_WIDTH-1:0]   cnt_q;

    // Pad ready to the full selection range so dest_q indexes without width games.
    always_comb begin
        ready_ext              = '0;
        ready_ext[NUM_OUT-1:0] = m_ready;
    end

    assign dest    = (state == LOCKED) ? lock_sel : s_sel;
    assign dest_ok = 32'(dest) < NUM_OUT;
    assign accept  = s_valid && s_ready;

    stream_pipe_reg #(.W(PW)) u_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && dest_ok),
        .in_ready  (s_ready),
        .in_data   ({s_data, s_last, dest}),
        .full      (full_q),
        .out_data  (reg_out),
        .out_ready (ready_ext[dest_q])
    );

    assign dest_q = reg_out[SEL_WIDTH-1:0];
    assign m_last = reg_out[SEL_WIDTH];
    assign m_data = reg_out[PW-1 -: WIDTH];

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_mvalid
        assign m_valid[i] = full_q && (dest_q == SEL_WIDTH'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_sel <= '0;
        end else if (accept) begin
            case (state)
                IDLE: if (!s_last) begin
                    state    <= LOCKED;
                    lock_sel <= s_sel;
                end
                LOCKED: if (s_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating: a stuck-at-max count is more useful than a wrapped one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (accept && !dest_ok && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Stream demux bench: transaction-level model checked every cycle plus directed literal checks.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic [1:0] s_sel = 2'd0;
    logic       s_last = 1'b0;
    logic [2:0] m_valid;
    logic [2:0] m_ready = 3'b111;
    logic [7:0] m_data;
    logic       m_last;
    logic [3:0] drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    stream_demux #(.WIDTH(8), .SEL_WIDTH(2), .NUM_OUT(3), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sel(s_sel), .s_last(s_last), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] port;
        logic [7:0] data;
        bit         last;
    } beat_t;

    // Model: the output register is a queue of at most one beat.
    beat_t      held[$];
    bit         locked = 1'b0;
    logic [1:0] lock_port = 2'd0;
    int         drops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (held.size() == 0) || m_ready[held[0].port];
    endfunction

    always @(posedge clk) begin : model
        bit         acc;
        logic [1:0] dest;
        if (!rst_n) begin
            held.delete();
            locked    = 1'b0;
            lock_port = 2'd0;
            drops     = 0;
        end else begin
            acc = s_valid && model_ready();
            if (held.size() != 0 && m_ready[held[0].port]) void'(held.pop_front());
            if (acc) begin
                dest = locked ? lock_port : s_sel;
                if (dest < 2'd3) held.push_back('{dest, s_data, s_last});
                else drops++;
                if (s_last) locked = 1'b0;
                else if (!locked) begin
                    locked    = 1'b1;
                    lock_port = s_sel;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (!rst_n) begin
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_s_ready", 32'(s_ready), 32'd1);
            check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
            check("rst_m_data", 32'(m_data), 32'd0);
        end else begin
            check("s_ready", 32'(s_ready), 32'(model_ready()));
            check("drop_cnt", 32'(drop_cnt), 32'((drops > 15) ? 15 : drops));
            if (held.size() == 0) begin
                check("m_valid_idle", 32'(m_valid), 32'd0);
            end else begin
                check("m_valid", 32'(m_valid), 32'(3'b001 << held[0].port));
                check("m_data", 32'(m_data), 32'(held[0].data));
                check("m_last", 32'(m_last), 32'(held[0].last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until it is accepted (bounded wait).
    task automatic beat(input logic [7:0] d, input logic [1:0] sel, input bit last);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_sel   = sel;
        s_last  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            step();
        end
        if (!done) begin
            miscompares++;
            $display("FAIL beat_timeout: data %0h never accepted", d);
        end
    endtask

    initial begin
        // Reset with s_valid asserted, then first beat.
        s_valid = 1'b1;
        s_data  = 8'hEE;
        repeat (2) step();
        rst_n   = 1'b1;
        beat(8'h5A, 2'd0, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("post_rst_m_valid", 32'(m_valid), 32'h1);
        check("post_rst_m_data", 32'(m_data), 32'h5A);
        step();

        // Streaming; s_sel changes mid-packet are ignored.
        beat(8'h11, 2'd2, 1'b0);
        beat(8'h12, 2'd0, 1'b0);
        beat(8'h13, 2'd0, 1'b0);
        beat(8'h14, 2'd0, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("stream_last_m_valid", 32'(m_valid), 32'h4);
        check("stream_last_data", 32'({m_last, m_data}), 32'h114);
        step();

        // Backpressure on port 1, other ports toggling.
        m_ready = 3'b101;
        beat(8'hA5, 2'd1, 1'b1);
        s_data = 8'hB6; s_sel = 2'd0; s_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_ready = {i[0], 1'b0, ~i[0]};
            @(negedge clk);
            check("bp_m_valid", 32'(m_valid), 32'h2);
            check("bp_m_data", 32'(m_data), 32'hA5);
            check("bp_s_ready", 32'(s_ready), 32'd0);
            step();
        end
        m_ready = 3'b111;
        @(negedge clk);
        check("bp_release_s_ready", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
        step();

        // Drops to the non-existent port 3, then a normal beat.
        beat(8'h21, 2'd3, 1'b0);
        beat(8'h22, 2'd0, 1'b0);
        beat(8'h23, 2'd1, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("drop_cnt_3", 32'(drop_cnt), 32'd3);
        check("drop_m_valid", 32'(m_valid), 32'd0);
        step();
        beat(8'h77, 2'd0, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("after_drop_m_valid", 32'(m_valid), 32'h1);
        step();

        // Saturation.
        for (int i = 0; i < 20; i++) beat(8'(i), 2'd3, 1'b1);
        s_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("drop_sat", 32'(drop_cnt), 32'd15);
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            s_sel   = 2'($urandom);
            s_last  = ($urandom_range(0, 2) == 0);
            m_ready = 3'($urandom) | 3'($urandom);
            step();
        end
        s_valid = 1'b0;
        m_ready = 3'b111;
        step();

        // Reset mid-packet clears the lock and the counter.
        beat(8'h31, 2'd1, 1'b0);
        beat(8'h32, 2'd1, 1'b0);
        s_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        beat(8'h33, 2'd2, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", 32'(m_valid), 32'h4);
        check("mid_rst_data", 32'(m_data), 32'h33);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
Registered stream demultiplexer, the write-side counterpart of the combinational mux: it steers one valid/ready input stream to one of NUM_OUT output ports selected by s_sel. Selection is locked per packet, from the first beat up to the s_last beat. Beats addressed to a non-existent port are accepted and discarded, and each discarded beat is counted. Sits between a single producer and banks of per-channel consumers in the essentials library.

Parameters:
WIDTH, 8, data bits per beat
SEL_WIDTH, 2, selection bits
NUM_OUT, 4, number of implemented output ports (1..2**SEL_WIDTH)
CNT_WIDTH, 8, width of the drop counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input beat valid
s_ready  output  1  input beat accepted when s_valid && s_ready
s_data  input  WIDTH  input payload
s_sel  input  SEL_WIDTH  destination port, sampled on the first beat of a packet
s_last  input  1  final beat of packet
m_valid  output  NUM_OUT  per-port valid; at most one bit high
m_ready  input  NUM_OUT  per-port ready
m_data  output  WIDTH  payload, shared by all ports
m_last  output  1  last flag, shared by all ports
drop_cnt  output  CNT_WIDTH  saturating count of discarded beats

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: full_q=0, m_valid=0, m_data=0, m_last=0, dest_q=0, state=IDLE, drop_cnt=0. Reset asserted mid-packet abandons the packet; the first beat after reset is treated as a packet head.
- Output stage is one register (full_q, data_q, last_q, dest_q).
  - m_valid[i] = full_q && (dest_q == i); m_data = data_q; m_last = last_q.
  - s_ready = !full_q || m_ready[dest_q]. It is combinational from m_ready, not from s_valid.
  - Latency is 1 cycle from acceptance to m_valid. Throughput is 1 beat/cycle while the destination stays ready (accept and drain happen in the same cycle).
- FSM, states IDLE and LOCKED:
  - IDLE: an accepted beat uses s_sel as its destination. If s_last=0, store lock_sel=s_sel and go to LOCKED. If s_last=1 (single-beat packet), stay in IDLE.
  - LOCKED: an accepted beat uses lock_sel; s_sel is ignored. Acceptance with s_last=1 returns to IDLE.
- Destinations:
  - Destination < NUM_OUT: the beat loads the register (full_q=1). m_valid stays high with m_data/m_last stable until m_ready[dest_q].
  - Destination >= NUM_OUT: the beat is accepted but not loaded, and drop_cnt increments. drop_cnt saturates at 2**CNT_WIDTH-1 and never wraps. A dropped beat still obeys s_ready.
  - If a drop and a drain occur in the same cycle, full_q goes to 0.
- Drain without refill (m_ready[dest_q]=1, no acceptance): full_q goes to 0 next cycle.
- Changes on m_ready of non-selected ports have no effect.
- When NUM_OUT == 2**SEL_WIDTH, no drops can occur and drop_cnt stays 0.

Decomposition:
- stream_demux_pkg holds the state_t enum (IDLE, LOCKED) and a localparam function for the output-count check (NUM_OUT <= 2**SEL_WIDTH, elaboration assertion).
- One sub-module, stream_pipe_reg: a single-entry valid/ready register with payload {data, last, dest}. stream_demux instantiates it and adds the FSM, the drop path and the m_valid decode.

Test Plan (WIDTH=8, SEL_WIDTH=2, NUM_OUT=3, CNT_WIDTH=4):
- Reset then idle: rst_n low for 2 cycles with s_valid=1 -> m_valid=000, s_ready=1, drop_cnt=0 throughout reset. First post-reset beat appears 1 cycle later.
- Streaming: 4-beat packet 0x11..0x14 with s_sel=2 and m_ready=111 -> m_valid=100 on 4 consecutive cycles, data in order, m_last on 0x14. Changing s_sel to 0 on beats 2-4 has no effect.
- Backpressure: head beat 0xA5 to port 1 with m_ready[1]=0 for 3 cycles -> m_valid=010, m_data=0xA5 held stable, s_ready=0. Toggling m_ready[0] and m_ready[2] has no effect. Release -> beat transfers, s_ready=1 the same cycle.
- Drop: 3-beat packet with s_sel=3 -> all 3 beats accepted back-to-back, m_valid=000, drop_cnt=3. Next single-beat packet with s_sel=0 is delivered normally.
- Saturation: 20 dropped beats -> drop_cnt=15 and stays at 15.
- Reset mid-packet: assert rst_n after beat 2 of a packet with s_sel=1, then send a beat with s_sel=2, s_last=1 -> it is delivered to port 2 (lock cleared), drop_cnt=0.
